// File: rtl/l2_gru_pkg.sv
// l2_gru_pkg: shared sizes, base addresses, vector type and FSM/group enums for the layer-2 gate result collector
package l2_gru_pkg;
  localparam int GATE_LEN = 32;
  localparam logic [6:0] BASE_Z = 7'h00;
  localparam logic [6:0] BASE_RH = 7'h20;
  localparam int PAIRS_Z = 16;
  localparam int PAIRS_RH = 32;
  typedef logic [31:0] vec32_t [GATE_LEN];
  typedef enum logic {IDLE, COLLECT} collect_state_t;
  typedef enum logic {GRP_Z, GRP_RH} gate_grp_t;
endpackage

// File: rtl/l2_gate_bank.sv
// l2_gate_bank: 32x32 register bank, writes d0 to q[idx] and d1 to q[idx+1] when we (clk, rst_n, we, idx, d0, d1 -> q)
module l2_gate_bank
  import l2_gru_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  idx,
  input  logic [31:0] d0,
  input  logic [31:0] d1,
  output vec32_t      q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < GATE_LEN; i++) q[i] <= '0;
    end else if (we) begin
      q[idx] <= d0;
      q[idx + 5'd1] <= d1;
    end
endmodule

// File: rtl/l2_gate_result_collector.sv
// l2_gate_result_collector: reassembles paired linear-stage results into z/r/h gate vectors (start/addr_base/in_done/din1/din2/out_ack in; z_vec/r_vec/h_vec/z_valid/rh_valid/busy/err out)
module l2_gate_result_collector
  import l2_gru_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [6:0]  addr_base,
  input  logic        in_done,
  input  logic [31:0] din1,
  input  logic [31:0] din2,
  input  logic        out_ack,
  output logic        z_valid,
  output logic        rh_valid,
  output vec32_t      z_vec,
  output vec32_t      r_vec,
  output vec32_t      h_vec,
  output logic        busy,
  output logic        err
);
  collect_state_t state;
  gate_grp_t grp;
  logic [4:0] k;
  logic legal, tgt_valid, accept, err_evt, wr, last, done_z, done_rh;
  gate_grp_t tgt_grp;
  always_comb begin
    legal = addr_base == BASE_Z || addr_base == BASE_RH;
    tgt_grp = addr_base == BASE_RH ? GRP_RH : GRP_Z;
    tgt_valid = tgt_grp == GRP_RH ? rh_valid : z_valid;
    accept = state == IDLE && start && legal && (!tgt_valid || out_ack);
    err_evt = (start && (!legal || state == COLLECT || (tgt_valid && !out_ack))) || (in_done && state == IDLE);
    wr = state == COLLECT && in_done;
    last = grp == GRP_Z ? k == 5'(PAIRS_Z - 1) : k == 5'(PAIRS_RH - 1);
    done_z = wr && last && grp == GRP_Z;
    done_rh = wr && last && grp == GRP_RH;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      grp <= GRP_Z;
      k <= '0;
      busy <= 1'b0;
      err <= 1'b0;
      z_valid <= 1'b0;
      rh_valid <= 1'b0;
    end else begin
      err <= err | err_evt;
      z_valid <= done_z | (z_valid & ~out_ack);
      rh_valid <= done_rh | (rh_valid & ~out_ack);
      if (accept) begin
        state <= COLLECT;
        grp <= tgt_grp;
        k <= '0;
        busy <= 1'b1;
      end else if (wr) begin
        k <= k + 5'd1;
        if (last) begin
          state <= IDLE;
          busy <= 1'b0;
        end
      end
    end
  l2_gate_bank u_z (.clk(clk), .rst_n(rst_n), .we(wr && grp == GRP_Z), .idx({k[3:0], 1'b0}),
                    .d0(din1), .d1(din2), .q(z_vec));
  l2_gate_bank u_r (.clk(clk), .rst_n(rst_n), .we(wr && grp == GRP_RH && !k[4]), .idx({k[3:0], 1'b0}),
                    .d0(din1), .d1(din2), .q(r_vec));
  l2_gate_bank u_h (.clk(clk), .rst_n(rst_n), .we(wr && grp == GRP_RH && k[4]), .idx({k[3:0], 1'b0}),
                    .d0(din1), .d1(din2), .q(h_vec));
endmodule

// File: tb/tb_l2_gate_result_collector.sv
// tb_l2_gate_result_collector: directed self-checking bench for l2_gate_result_collector
module tb_l2_gate_result_collector;
  import l2_gru_pkg::*;
  logic clk = 1'b0;
  logic rst_n, start, in_done, out_ack;
  logic [6:0] addr_base;
  logic [31:0] din1, din2;
  logic z_valid, rh_valid, busy, err;
  vec32_t z_vec, r_vec, h_vec;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  l2_gate_result_collector dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr_base(addr_base), .in_done(in_done),
    .din1(din1), .din2(din2), .out_ack(out_ack), .z_valid(z_valid), .rh_valid(rh_valid),
    .z_vec(z_vec), .r_vec(r_vec), .h_vec(h_vec), .busy(busy), .err(err)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    start = 1'b0;
    in_done = 1'b0;
    out_ack = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
  endtask
  task automatic send_pass(input logic [6:0] base, input int vbase, input int npairs, input bit ack_last);
    start = 1'b1;
    addr_base = base;
    tick;
    start = 1'b0;
    for (int k = 0; k < npairs; k++) begin
      in_done = 1'b1;
      din1 = 32'(vbase + 2 * k);
      din2 = 32'(vbase + 2 * k + 1);
      out_ack = ack_last && k == npairs - 1;
      tick;
    end
    in_done = 1'b0;
    out_ack = 1'b0;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    tick;
    n_cmp += 4;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b exp 0", busy); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b exp 0", err); end
    if (z_valid !== 1'b0) begin n_bad++; $display("FAIL reset_z_valid: got %b exp 0", z_valid); end
    if (rh_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rh_valid: got %b exp 0", rh_valid); end
    for (int i = 0; i < GATE_LEN; i++) begin
      n_cmp++;
      if (z_vec[i] !== 32'h0 || r_vec[i] !== 32'h0 || h_vec[i] !== 32'h0) begin
        n_bad++;
        $display("FAIL reset_vec[%0d]: got z=%h r=%h h=%h exp 0", i, z_vec[i], r_vec[i], h_vec[i]);
      end
    end
    rst_n = 1'b1;
    tick;
  endtask
  task automatic test_z_pass;
    start = 1'b1;
    addr_base = 7'h00;
    tick;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL z_busy_rise: got %b exp 1", busy); end
    for (int k = 0; k < 16; k++) begin
      in_done = 1'b1;
      din1 = 32'(2 * k);
      din2 = 32'(2 * k + 1);
      tick;
      if (k == 14) begin
        n_cmp += 2;
        if (z_valid !== 1'b0) begin n_bad++; $display("FAIL z_valid_early: got %b exp 0", z_valid); end
        if (busy !== 1'b1) begin n_bad++; $display("FAIL z_busy_mid: got %b exp 1", busy); end
      end
    end
    in_done = 1'b0;
    n_cmp += 3;
    if (z_valid !== 1'b1) begin n_bad++; $display("FAIL z_valid: got %b exp 1", z_valid); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL z_busy_fall: got %b exp 0", busy); end
    if (rh_valid !== 1'b0) begin n_bad++; $display("FAIL z_rh_valid: got %b exp 0", rh_valid); end
    for (int i = 0; i < GATE_LEN; i++) begin
      n_cmp++;
      if (z_vec[i] !== 32'(i)) begin n_bad++; $display("FAIL z_vec[%0d]: got %h exp %h", i, z_vec[i], 32'(i)); end
    end
  endtask
  task automatic test_rh_pass;
    send_pass(7'h20, 32'h100, 32, 1'b0);
    n_cmp += 4;
    if (rh_valid !== 1'b1) begin n_bad++; $display("FAIL rh_valid: got %b exp 1", rh_valid); end
    if (z_valid !== 1'b1) begin n_bad++; $display("FAIL rh_z_valid_kept: got %b exp 1", z_valid); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rh_busy: got %b exp 0", busy); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL rh_err: got %b exp 0", err); end
    for (int i = 0; i < GATE_LEN; i++) begin
      n_cmp += 2;
      if (r_vec[i] !== 32'(32'h100 + i)) begin n_bad++; $display("FAIL r_vec[%0d]: got %h exp %h", i, r_vec[i], 32'(32'h100 + i)); end
      if (h_vec[i] !== 32'(32'h120 + i)) begin n_bad++; $display("FAIL h_vec[%0d]: got %h exp %h", i, h_vec[i], 32'(32'h120 + i)); end
    end
    out_ack = 1'b1;
    tick;
    out_ack = 1'b0;
    n_cmp += 2;
    if (z_valid !== 1'b0) begin n_bad++; $display("FAIL ack_z_valid: got %b exp 0", z_valid); end
    if (rh_valid !== 1'b0) begin n_bad++; $display("FAIL ack_rh_valid: got %b exp 0", rh_valid); end
  endtask
  task automatic test_gapped;
    start = 1'b1;
    addr_base = 7'h20;
    tick;
    start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      in_done = 1'b1;
      din1 = 32'(32'h300 + 2 * k);
      din2 = 32'(32'h300 + 2 * k + 1);
      tick;
      in_done = 1'b0;
      if (k < 31) begin
        for (int g = 0; g < 2; g++) begin
          n_cmp++;
          if (busy !== 1'b1) begin n_bad++; $display("FAIL gap_busy k=%0d: got %b exp 1", k, busy); end
          tick;
        end
      end
    end
    n_cmp += 2;
    if (rh_valid !== 1'b1) begin n_bad++; $display("FAIL gap_rh_valid: got %b exp 1", rh_valid); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL gap_busy_end: got %b exp 0", busy); end
    for (int i = 0; i < GATE_LEN; i++) begin
      n_cmp += 2;
      if (r_vec[i] !== 32'(32'h300 + i)) begin n_bad++; $display("FAIL gap_r_vec[%0d]: got %h exp %h", i, r_vec[i], 32'(32'h300 + i)); end
      if (h_vec[i] !== 32'(32'h320 + i)) begin n_bad++; $display("FAIL gap_h_vec[%0d]: got %h exp %h", i, h_vec[i], 32'(32'h320 + i)); end
    end
    out_ack = 1'b1;
    tick;
    out_ack = 1'b0;
  endtask
  task automatic test_err_idle_done;
    do_reset;
    send_pass(7'h00, 32'h40, 16, 1'b0);
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL idle_done_pre_err: got %b exp 0", err); end
    in_done = 1'b1;
    din1 = 32'hdead;
    din2 = 32'hbeef;
    tick;
    in_done = 1'b0;
    n_cmp += 6;
    if (err !== 1'b1) begin n_bad++; $display("FAIL idle_done_err: got %b exp 1", err); end
    if (z_vec[0] !== 32'h40) begin n_bad++; $display("FAIL idle_done_z0: got %h exp 40", z_vec[0]); end
    if (z_vec[31] !== 32'h5f) begin n_bad++; $display("FAIL idle_done_z31: got %h exp 5f", z_vec[31]); end
    if (r_vec[0] !== 32'h0) begin n_bad++; $display("FAIL idle_done_r0: got %h exp 0", r_vec[0]); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_done_busy: got %b exp 0", busy); end
    if (z_valid !== 1'b1) begin n_bad++; $display("FAIL idle_done_z_valid: got %b exp 1", z_valid); end
  endtask
  task automatic test_err_bad_base;
    do_reset;
    start = 1'b1;
    addr_base = 7'h10;
    tick;
    start = 1'b0;
    n_cmp += 2;
    if (err !== 1'b1) begin n_bad++; $display("FAIL bad_base_err: got %b exp 1", err); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL bad_base_busy: got %b exp 0", busy); end
    tick;
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL bad_base_busy2: got %b exp 0", busy); end
  endtask
  task automatic test_err_start_valid;
    do_reset;
    send_pass(7'h00, 32'h80, 16, 1'b0);
    start = 1'b1;
    addr_base = 7'h00;
    tick;
    start = 1'b0;
    n_cmp += 4;
    if (err !== 1'b1) begin n_bad++; $display("FAIL start_valid_err: got %b exp 1", err); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL start_valid_busy: got %b exp 0", busy); end
    if (z_valid !== 1'b1) begin n_bad++; $display("FAIL start_valid_z_valid: got %b exp 1", z_valid); end
    if (z_vec[3] !== 32'h83) begin n_bad++; $display("FAIL start_valid_z3: got %h exp 83", z_vec[3]); end
    send_pass(7'h00, 32'h90, 16, 1'b0);
    n_cmp += 2;
    if (z_vec[0] !== 32'h80) begin n_bad++; $display("FAIL start_valid_rejected_z0: got %h exp 80", z_vec[0]); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL start_valid_rejected_busy: got %b exp 0", busy); end
    start = 1'b1;
    out_ack = 1'b1;
    tick;
    start = 1'b0;
    out_ack = 1'b0;
    n_cmp += 2;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL start_ack_busy: got %b exp 1", busy); end
    if (z_valid !== 1'b0) begin n_bad++; $display("FAIL start_ack_z_valid: got %b exp 0", z_valid); end
  endtask
  task automatic test_err_start_busy;
    do_reset;
    start = 1'b1;
    addr_base = 7'h00;
    tick;
    addr_base = 7'h20;
    tick;
    start = 1'b0;
    n_cmp += 2;
    if (err !== 1'b1) begin n_bad++; $display("FAIL start_busy_err: got %b exp 1", err); end
    if (busy !== 1'b1) begin n_bad++; $display("FAIL start_busy_busy: got %b exp 1", busy); end
    for (int k = 0; k < 16; k++) begin
      in_done = 1'b1;
      din1 = 32'(32'ha0 + 2 * k);
      din2 = 32'(32'ha0 + 2 * k + 1);
      tick;
    end
    in_done = 1'b0;
    n_cmp += 4;
    if (z_valid !== 1'b1) begin n_bad++; $display("FAIL start_busy_z_valid: got %b exp 1", z_valid); end
    if (rh_valid !== 1'b0) begin n_bad++; $display("FAIL start_busy_rh_valid: got %b exp 0", rh_valid); end
    if (z_vec[31] !== 32'hbf) begin n_bad++; $display("FAIL start_busy_z31: got %h exp bf", z_vec[31]); end
    if (r_vec[0] !== 32'h0) begin n_bad++; $display("FAIL start_busy_r0: got %h exp 0", r_vec[0]); end
  endtask
  task automatic test_simultaneous;
    do_reset;
    send_pass(7'h20, 32'h100, 32, 1'b0);
    n_cmp++;
    if (rh_valid !== 1'b1) begin n_bad++; $display("FAIL sim_rh_pre: got %b exp 1", rh_valid); end
    send_pass(7'h00, 32'h700, 16, 1'b1);
    n_cmp += 4;
    if (z_valid !== 1'b1) begin n_bad++; $display("FAIL sim_z_valid: got %b exp 1", z_valid); end
    if (rh_valid !== 1'b0) begin n_bad++; $display("FAIL sim_rh_valid: got %b exp 0", rh_valid); end
    if (z_vec[5] !== 32'h705) begin n_bad++; $display("FAIL sim_z5: got %h exp 705", z_vec[5]); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL sim_err: got %b exp 0", err); end
  endtask
  task automatic test_reset_mid;
    start = 1'b1;
    addr_base = 7'h00;
    out_ack = 1'b1;
    tick;
    start = 1'b0;
    out_ack = 1'b0;
    for (int k = 0; k < 7; k++) begin
      in_done = 1'b1;
      din1 = 32'(32'h500 + 2 * k);
      din2 = 32'(32'h500 + 2 * k + 1);
      tick;
    end
    in_done = 1'b0;
    n_cmp += 2;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_pre: got %b exp 1", busy); end
    if (z_vec[13] !== 32'h50d) begin n_bad++; $display("FAIL mid_z13_pre: got %h exp 50d", z_vec[13]); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp += 6;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b exp 0", busy); end
    if (z_valid !== 1'b0) begin n_bad++; $display("FAIL mid_z_valid: got %b exp 0", z_valid); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL mid_err: got %b exp 0", err); end
    if (z_vec[0] !== 32'h0) begin n_bad++; $display("FAIL mid_z0: got %h exp 0", z_vec[0]); end
    if (z_vec[13] !== 32'h0) begin n_bad++; $display("FAIL mid_z13: got %h exp 0", z_vec[13]); end
    if (r_vec[0] !== 32'h0) begin n_bad++; $display("FAIL mid_r0: got %h exp 0", r_vec[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    send_pass(7'h00, 32'h600, 16, 1'b0);
    n_cmp += 2;
    if (z_valid !== 1'b1) begin n_bad++; $display("FAIL post_z_valid: got %b exp 1", z_valid); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL post_err: got %b exp 0", err); end
    for (int i = 0; i < GATE_LEN; i++) begin
      n_cmp++;
      if (z_vec[i] !== 32'(32'h600 + i)) begin n_bad++; $display("FAIL post_z_vec[%0d]: got %h exp %h", i, z_vec[i], 32'(32'h600 + i)); end
    end
  endtask
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    addr_base = 7'h00;
    in_done = 1'b0;
    din1 = '0;
    din2 = '0;
    out_ack = 1'b0;
    test_reset;
    test_z_pass;
    test_rh_pass;
    test_gapped;
    test_err_idle_done;
    test_err_bad_base;
    test_err_start_valid;
    test_err_start_busy;
    test_simultaneous;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
